// File: rtl/seg7_scan_if.sv
// Display-side bundle for seg7_scan_driver: digit codes and controls in, scanned segment/enable pins out.
interface seg7_scan_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic                    rbi_n;
  logic                    lt_n;
  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    rbo_n;

  modport master (output value, load, rbi_n, lt_n, input seg_n, an_n, rbo_n);
  modport slave  (input value, load, rbi_n, lt_n, output seg_n, an_n, rbo_n);
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed multi-digit 7-segment driver with ripple blanking and lamp test.
// Optional macro SEG7_HEX_EN: codes 10-15 decode to hex glyphs instead of blanking.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned PRESCALE   = 1000,
  parameter int unsigned KEEP_LSD   = 1
) (
  input logic        clk,
  input logic        rst_n,
  seg7_scan_if.slave bus
);
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [VAL_W-1:0]      shadow_q, shadow_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            seg_n_q, seg_n_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic                  rbo_n_q, rbo_n_d;

  logic [NUM_DIGITS-1:0] zero_from;
  logic                  zero_acc;
  logic [3:0]            cur_code;
  logic                  cur_zero_from;
  logic                  blank;

  // Active-high glyph, bit0 = a; an all-zero glyph means a dark digit
  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'h0:    glyph = 7'h3F;
      4'h1:    glyph = 7'h06;
      4'h2:    glyph = 7'h5B;
      4'h3:    glyph = 7'h4F;
      4'h4:    glyph = 7'h66;
      4'h5:    glyph = 7'h6D;
      4'h6:    glyph = 7'h7D;
      4'h7:    glyph = 7'h07;
      4'h8:    glyph = 7'h7F;
      4'h9:    glyph = 7'h6F;
`ifdef SEG7_HEX_EN
      4'hA:    glyph = 7'h77;
      4'hB:    glyph = 7'h7C;
      4'hC:    glyph = 7'h39;
      4'hD:    glyph = 7'h5E;
      4'hE:    glyph = 7'h79;
      4'hF:    glyph = 7'h71;
`endif
      default: glyph = 7'h00;
    endcase
  endfunction

  // Shadow capture and prescaled scan index
  always_comb begin
    shadow_d = bus.load ? bus.value : shadow_q;
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    if (cnt_q == CNT_W'(PRESCALE - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // zero_from[i]: digits NUM_DIGITS-1 down to i are all code 0
  always_comb begin
    zero_acc  = 1'b1;
    zero_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_acc     = zero_acc & (shadow_q[4*i +: 4] == 4'h0);
      zero_from[i] = zero_acc;
    end
  end

  always_comb begin
    cur_code      = 4'h0;
    cur_zero_from = 1'b0;
    an_n_d        = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_code      = shadow_q[4*i +: 4];
        cur_zero_from = zero_from[i];
        an_n_d[i]     = 1'b0;
      end
    end
    blank   = !bus.rbi_n && cur_zero_from && !((KEEP_LSD != 0) && (idx_q == '0));
    seg_n_d = ~glyph(cur_code);
    if (!bus.lt_n)  seg_n_d = 7'h00;
    else if (blank) seg_n_d = 7'h7F;
    rbo_n_d = !(!bus.rbi_n && zero_from[0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      seg_n_q  <= 7'h7F;
      an_n_q   <= '1;
      rbo_n_q  <= 1'b1;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      seg_n_q  <= seg_n_d;
      an_n_q   <= an_n_d;
      rbo_n_q  <= rbo_n_d;
    end
  end

  assign bus.seg_n = seg_n_q;
  assign bus.an_n  = an_n_q;
  assign bus.rbo_n = rbo_n_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: one KEEP_LSD=1 and one KEEP_LSD=0 instance share stimulus.
module tb_seg7_scan_driver;
  localparam int unsigned ND = 4;
  localparam int unsigned PS = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg7_scan_if #(.NUM_DIGITS(ND)) if1 ();
  seg7_scan_if #(.NUM_DIGITS(ND)) if0 ();

  seg7_scan_driver #(.NUM_DIGITS(ND), .PRESCALE(PS), .KEEP_LSD(1)) dut_k1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));
  seg7_scan_driver #(.NUM_DIGITS(ND), .PRESCALE(PS), .KEEP_LSD(0)) dut_k0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));

  typedef struct {
    logic [15:0]     value;
    logic            rbi_n;
    logic            lt_n;
    logic [3:0][6:0] seg;      // expected per digit, KEEP_LSD=1
    logic [6:0]      seg0_k0;  // expected digit 0 for KEEP_LSD=0
    logic            rbo_n;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] v, input logic ld, input logic rbi, input logic lt);
    if1.value = v; if1.load = ld; if1.rbi_n = rbi; if1.lt_n = lt;
    if0.value = v; if0.load = ld; if0.rbi_n = rbi; if0.lt_n = lt;
  endtask

  function automatic int an_idx(input logic [3:0] an);
    case (an)
      4'b1110: an_idx = 0;
      4'b1101: an_idx = 1;
      4'b1011: an_idx = 2;
      4'b0111: an_idx = 3;
      default: an_idx = -1;
    endcase
  endfunction

  // Observe one full frame and compare each displayed digit against the record
  task automatic run_frame(input vec_t v, input string tag);
    int d;
    for (int k = 0; k < int'(ND * PS); k++) begin
      @(negedge clk);
      d = an_idx(if1.an_n);
      check($sformatf("%s_k%0d_an_valid", tag, k), 8'(d >= 0), 8'd1);
      check($sformatf("%s_k%0d_an_match", tag, k), 8'(if0.an_n), 8'(if1.an_n));
      check($sformatf("%s_k%0d_rbo", tag, k), 8'(if1.rbo_n), 8'(v.rbo_n));
      check($sformatf("%s_k%0d_rbo_k0", tag, k), 8'(if0.rbo_n), 8'(v.rbo_n));
      if (d >= 0) begin
        check($sformatf("%s_d%0d_seg", tag, d), 8'(if1.seg_n), 8'(v.seg[d]));
        check($sformatf("%s_d%0d_seg_k0", tag, d), 8'(if0.seg_n),
              8'((d == 0) ? v.seg0_k0 : v.seg[d]));
      end
    end
  endtask

  initial begin
    logic [6:0]      seg_b;
    logic [3:0]      exp_an;
    logic [3:0][6:0] old_g, new_g;
    int              d;

`ifdef SEG7_HEX_EN
    seg_b = 7'h03;
`else
    seg_b = 7'h7F;
`endif
    vecs[0] = '{16'h1234, 1'b1, 1'b1, {7'h79, 7'h24, 7'h30, 7'h19}, 7'h19, 1'b1};
    vecs[1] = '{16'h0050, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 7'h40, 1'b1};
    vecs[2] = '{16'h0000, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 7'h7F, 1'b0};
    vecs[3] = '{16'h0000, 1'b0, 1'b0, {7'h00, 7'h00, 7'h00, 7'h00}, 7'h00, 1'b0};
    vecs[4] = '{16'h0050, 1'b1, 1'b1, {7'h40, 7'h40, 7'h12, 7'h40}, 7'h40, 1'b1};
    vecs[5] = '{16'h00B0, 1'b0, 1'b1, {7'h7F, 7'h7F, seg_b, 7'h40}, 7'h40, 1'b1};
    vecs[6] = '{16'hB000, 1'b0, 1'b1, {seg_b, 7'h40, 7'h40, 7'h40}, 7'h40, 1'b1};
    vecs[7] = '{16'h0800, 1'b0, 1'b1, {7'h7F, 7'h00, 7'h40, 7'h40}, 7'h40, 1'b1};
    vecs[8] = '{16'h9076, 1'b0, 1'b1, {7'h10, 7'h40, 7'h78, 7'h02}, 7'h02, 1'b1};

    // Reset state
    rst_n = 1'b0;
    drive(16'h0000, 1'b0, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check("rst_seg", 8'(if1.seg_n), 8'h7F);
    check("rst_an", 8'(if1.an_n), 8'h0F);
    check("rst_rbo", 8'(if1.rbo_n), 8'h01);

    // Scan order and hold time from release; shadow is still zero
    rst_n = 1'b1;
    for (int k = 0; k < int'(2 * ND * PS); k++) begin
      @(negedge clk);
      exp_an = ~(4'b0001 << ((k / int'(PS)) % int'(ND)));
      check($sformatf("scan_k%0d_an", k), 8'(if1.an_n), 8'(exp_an));
      if (k == 0) check("first_digit_seg", 8'(if1.seg_n), 8'h40);
    end

    // Table-driven frames
    for (int vi = 0; vi < NV; vi++) begin
      drive(vecs[vi].value, 1'b1, vecs[vi].rbi_n, vecs[vi].lt_n);
      @(negedge clk);
      drive(vecs[vi].value, 1'b0, vecs[vi].rbi_n, vecs[vi].lt_n);
      run_frame(vecs[vi], $sformatf("v%0d", vi));
    end

    // value changes without load must not disturb the display
    drive(16'h1111, 1'b0, vecs[NV-1].rbi_n, vecs[NV-1].lt_n);
    run_frame(vecs[NV-1], "tear");

    // Load latency: old data at the load edge, new data one edge later
    drive(16'h1234, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    drive(16'h1234, 1'b0, 1'b1, 1'b1);
    run_frame(vecs[0], "pre_load");
    old_g = {7'h79, 7'h24, 7'h30, 7'h19};
    new_g = {7'h12, 7'h02, 7'h78, 7'h00};
    drive(16'h5678, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    d = an_idx(if1.an_n);
    check("load_edge_valid", 8'(d >= 0), 8'd1);
    if (d >= 0) check("load_edge_old", 8'(if1.seg_n), 8'(old_g[d]));
    drive(16'h5678, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    d = an_idx(if1.an_n);
    check("load_next_valid", 8'(d >= 0), 8'd1);
    if (d >= 0) check("load_next_new", 8'(if1.seg_n), 8'(new_g[d]));

    // rbi_n and lt_n latency on a zero shadow
    drive(16'h0000, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    drive(16'h0000, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("rbi_hi_rbo", 8'(if1.rbo_n), 8'h01);
    drive(16'h0000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("rbi_lo_rbo", 8'(if1.rbo_n), 8'h00);
    d = an_idx(if1.an_n);
    check("rbi_lo_valid", 8'(d >= 0), 8'd1);
    check("rbi_lo_seg", 8'(if1.seg_n), (d == 0) ? 8'h40 : 8'h7F);
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("lt_seg", 8'(if1.seg_n), 8'h00);
    check("lt_seg_k0", 8'(if0.seg_n), 8'h00);
    check("lt_rbo", 8'(if1.rbo_n), 8'h00);

    // Asynchronous reset mid-scan, then restart at digit 0 with cleared shadow
    drive(16'h1234, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    drive(16'h1234, 1'b0, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_seg", 8'(if1.seg_n), 8'h7F);
    check("async_rst_an", 8'(if1.an_n), 8'h0F);
    check("async_rst_rbo", 8'(if1.rbo_n), 8'h01);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_an", 8'(if1.an_n), 8'h0E);
    check("restart_seg", 8'(if1.seg_n), 8'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
